// File: rtl/ram_march_bist_pkg.sv
// Shared definitions for the March C- RAM BIST engine.
// Holds the FSM state type and the per-element tables: address direction,
// which ops the element performs, and which background each op uses
// (background 0 = all-zeros word, background 1 = all-ones word).
package ram_march_bist_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_M0,
    S_M1,
    S_M2,
    S_M3,
    S_M4,
    S_M5,
    S_DRAIN,
    S_DONE
  } state_t;

  // Ascending address order for the element (M3/M4 walk down).
  function automatic logic elem_up(input state_t s);
    case (s)
      S_M3, S_M4: return 1'b0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic elem_has_read(input state_t s);
    case (s)
      S_M1, S_M2, S_M3, S_M4, S_M5: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic elem_has_write(input state_t s);
    case (s)
      S_M0, S_M1, S_M2, S_M3, S_M4: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  // Background bit expected by the element's read.
  function automatic logic elem_rd_bg(input state_t s);
    case (s)
      S_M2, S_M4: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  // Background bit written by the element's write.
  function automatic logic elem_wr_bg(input state_t s);
    case (s)
      S_M1, S_M3: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic state_t next_elem(input state_t s);
    case (s)
      S_M0:    return S_M1;
      S_M1:    return S_M2;
      S_M2:    return S_M3;
      S_M3:    return S_M4;
      S_M4:    return S_M5;
      S_M5:    return S_DRAIN;
      default: return S_IDLE;
    endcase
  endfunction

  // Two-op elements read in phase 0 and write in phase 1.
  function automatic logic op_write(input state_t s, input logic phase);
    return elem_has_write(s) && (!elem_has_read(s) || phase);
  endfunction

  function automatic logic op_read(input state_t s, input logic phase);
    return elem_has_read(s) && (!elem_has_write(s) || !phase);
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter for the march engine.
//  clk, reset : clock, synchronous active-high reset
//  load       : jump to the first address of a new element; latches direction
//  en         : step one address in the latched direction
//  up         : direction for the element being loaded
//  addr       : current address (registered)
//  is_last    : current address is the final one for the latched direction
module ram_bist_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  input  logic              up,
  output logic [ADDR_W-1:0] addr,
  output logic              is_last
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic dir_up;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr   <= '0;
      dir_up <= 1'b1;
    end else if (load) begin
      addr   <= up ? '0 : LAST;
      dir_up <= up;
    end else if (en) begin
      addr   <= dir_up ? addr + 1'b1 : addr - 1'b1;
    end
  end

  always_comb begin
    is_last = dir_up ? (addr == LAST) : (addr == '0);
  end

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST engine driving a single-port RAM with 1-cycle read latency.
//  clk, reset     : clock, synchronous active-high reset
//  start          : begin test (accepted only in IDLE/DONE)
//  busy / done    : march running / one-cycle completion pulse
//  pass           : no mismatches in the last run (valid after done)
//  err_count      : saturating mismatch count
//  fail_addr/fail_expect/fail_data : capture of the first mismatch
//  ram_address/ram_write/ram_data_in : registered RAM controls
//  ram_data_out   : RAM read data, valid the cycle after a read op
module ram_march_bist
  import ram_march_bist_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 1024,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_expect,
  output logic [DATA_W-1:0] fail_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  state_t            state, state_nxt;
  logic              phase, phase_nxt;
  logic              ag_load, ag_en, ag_up, is_last;
  logic              rd_pend;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] exp_addr;
  logic              mismatch, abort, start_acc;

  ram_bist_addr_gen #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .load   (ag_load),
    .en     (ag_en),
    .up     (ag_up),
    .addr   (ram_address),
    .is_last(is_last)
  );

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    ag_load   = 1'b0;
    ag_en     = 1'b0;
    ag_up     = 1'b1;
    start_acc = 1'b0;
    mismatch  = rd_pend && (ram_data_out != exp_q);
    abort     = mismatch && (STOP_ON_FAIL != 0);
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (start) begin
          start_acc = 1'b1;
          state_nxt = S_M0;
          phase_nxt = 1'b0;
          ag_load   = 1'b1;
          ag_up     = 1'b1;
        end
      end
      S_DRAIN: state_nxt = S_DONE;
      default: begin
        if (elem_has_read(state) && elem_has_write(state) && !phase) begin
          phase_nxt = 1'b1;
        end else begin
          phase_nxt = 1'b0;
          if (is_last) begin
            state_nxt = next_elem(state);
            ag_load   = 1'b1;
            ag_up     = elem_up(next_elem(state));
          end else begin
            ag_en = 1'b1;
          end
        end
      end
    endcase
    if (abort) begin
      state_nxt = S_DONE;
      phase_nxt = 1'b0;
      ag_load   = 1'b0;
      ag_en     = 1'b0;
    end
  end

  always_comb begin
    busy = (state != S_IDLE) && (state != S_DONE);
    done = (state == S_DONE);
  end

  // ram_write/ram_data_in are registered from the next state/phase so they
  // line up with ram_address, which the counter already holds as a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      phase       <= 1'b0;
      ram_write   <= 1'b0;
      ram_data_in <= '0;
      rd_pend     <= 1'b0;
      exp_q       <= '0;
      exp_addr    <= '0;
      err_count   <= '0;
      fail_addr   <= '0;
      fail_expect <= '0;
      fail_data   <= '0;
      pass        <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      ram_write   <= op_write(state_nxt, phase_nxt);
      ram_data_in <= {DATA_W{elem_wr_bg(state_nxt)}};
      rd_pend     <= op_read(state, phase) && !abort;
      if (op_read(state, phase)) begin
        exp_q    <= {DATA_W{elem_rd_bg(state)}};
        exp_addr <= ram_address;
      end
      if (start_acc) begin
        err_count   <= '0;
        fail_addr   <= '0;
        fail_expect <= '0;
        fail_data   <= '0;
        pass        <= 1'b0;
      end else begin
        if (mismatch) begin
          if (err_count != '1) err_count <= err_count + 16'd1;
          if (err_count == '0) begin
            fail_addr   <= exp_addr;
            fail_expect <= exp_q;
            fail_data   <= ram_data_out;
          end
        end
        if (state_nxt == S_DONE && state != S_DONE) begin
          pass <= (err_count == '0) && !mismatch;
        end
      end
    end
  end

endmodule
